// File: rtl/memref_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between two requesters.
// Reads are tagged through a RD_LATENCY-deep pipe so each response returns to its issuer.
module memref_port_arbiter #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req0_valid,
  output logic                  o_req0_ready,
  input  logic                  i_req0_we,
  input  logic [ADDR_WIDTH-1:0] i_req0_addr,
  input  logic [WIDTH-1:0]      i_req0_wdata,
  input  logic                  i_req1_valid,
  output logic                  o_req1_ready,
  input  logic                  i_req1_we,
  input  logic [ADDR_WIDTH-1:0] i_req1_addr,
  input  logic [WIDTH-1:0]      i_req1_wdata,
  output logic                  o_rsp0_valid,
  output logic [WIDTH-1:0]      o_rsp0_data,
  output logic                  o_rsp1_valid,
  output logic [WIDTH-1:0]      o_rsp1_data,
  output logic                  o_mem_ce,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [WIDTH-1:0]      o_mem_wdata,
  input  logic [WIDTH-1:0]      i_mem_rdata
);

  logic                  r_prio;
  logic [RD_LATENCY-1:0] r_sr_vld;
  logic [RD_LATENCY-1:0] r_sr_id;

  logic w_gnt0;
  logic w_gnt1;
  logic w_load_vld;
  logic w_tail_vld;
  logic w_tail_id;

  // Grants are gated by reset so nothing reaches the memory while held in reset.
  assign w_gnt0 = i_rst_n & i_req0_valid & (~i_req1_valid | ~r_prio);
  assign w_gnt1 = i_rst_n & i_req1_valid & (~i_req0_valid |  r_prio);

  assign o_req0_ready = w_gnt0;
  assign o_req1_ready = w_gnt1;

  always_comb begin
    o_mem_ce    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (w_gnt0) begin
      o_mem_ce    = 1'b1;
      o_mem_we    = i_req0_we;
      o_mem_addr  = i_req0_addr;
      o_mem_wdata = i_req0_wdata;
    end else if (w_gnt1) begin
      o_mem_ce    = 1'b1;
      o_mem_we    = i_req1_we;
      o_mem_addr  = i_req1_addr;
      o_mem_wdata = i_req1_wdata;
    end
  end

  assign w_load_vld = (w_gnt0 & ~i_req0_we) | (w_gnt1 & ~i_req1_we);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prio   <= 1'b0;
      r_sr_vld <= '0;
      r_sr_id  <= '0;
    end else begin
      if (w_gnt0) begin
        r_prio <= 1'b1;
      end else if (w_gnt1) begin
        r_prio <= 1'b0;
      end
      r_sr_vld[0] <= w_load_vld;
      r_sr_id[0]  <= w_gnt1;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_sr_vld[i] <= r_sr_vld[i-1];
        r_sr_id[i]  <= r_sr_id[i-1];
      end
    end
  end

  assign w_tail_vld = r_sr_vld[RD_LATENCY-1];
  assign w_tail_id  = r_sr_id[RD_LATENCY-1];

  assign o_rsp0_valid = w_tail_vld & ~w_tail_id;
  assign o_rsp1_valid = w_tail_vld &  w_tail_id;
  assign o_rsp0_data  = o_rsp0_valid ? i_mem_rdata : '0;
  assign o_rsp1_data  = o_rsp1_valid ? i_mem_rdata : '0;

endmodule

// File: tb/tb_memref_port_arbiter.sv
// Directed and randomized checks of memref_port_arbiter at read latencies 1, 2 and 3.
// All three instances share the request inputs; each has its own memory model.
module tb_memref_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_we, req1_valid, req1_we;
  logic [9:0]  req0_addr, req1_addr;
  logic [31:0] req0_wdata, req1_wdata;
  logic        bd_we;
  logic [9:0]  bd_addr;
  logic [31:0] bd_data;

  logic        rdy0 [3];
  logic        rdy1 [3];
  logic        rv0  [3];
  logic        rv1  [3];
  logic        mce  [3];
  logic        mwe  [3];
  logic [9:0]  maddr[3];
  logic [31:0] mwd  [3];
  logic [31:0] mrd  [3];
  logic [31:0] rd0  [3];
  logic [31:0] rd1  [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    logic [31:0] mem  [1024];
    logic [31:0] pipe [4];

    memref_port_arbiter #(.WIDTH(32), .ADDR_WIDTH(10), .RD_LATENCY(k + 1)) u_dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_req0_valid (req0_valid),
      .o_req0_ready (rdy0[k]),
      .i_req0_we    (req0_we),
      .i_req0_addr  (req0_addr),
      .i_req0_wdata (req0_wdata),
      .i_req1_valid (req1_valid),
      .o_req1_ready (rdy1[k]),
      .i_req1_we    (req1_we),
      .i_req1_addr  (req1_addr),
      .i_req1_wdata (req1_wdata),
      .o_rsp0_valid (rv0[k]),
      .o_rsp0_data  (rd0[k]),
      .o_rsp1_valid (rv1[k]),
      .o_rsp1_data  (rd1[k]),
      .o_mem_ce     (mce[k]),
      .o_mem_we     (mwe[k]),
      .o_mem_addr   (maddr[k]),
      .o_mem_wdata  (mwd[k]),
      .i_mem_rdata  (mrd[k])
    );

    // Single-port memory with a read pipeline of k+1 registers.
    always @(posedge clk) begin
      pipe[0] <= mem[maddr[k]];
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
      if (mce[k] && mwe[k]) mem[maddr[k]] <= mwd[k];
      if (bd_we) mem[bd_addr] <= bd_data;
    end
    assign mrd[k] = pipe[k];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
  endtask

  task automatic load(input int a, input logic [31:0] d);
    bd_addr = a[9:0]; bd_data = d; bd_we = 1'b1;
    tick();
    bd_we = 1'b0;
  endtask

  typedef struct {
    int          due;
    bit          id;
    logic [31:0] data;
  } exp_t;

  initial begin
    logic [31:0] shadow [16];
    exp_t        q [$];
    bit          pend0, pend1, ev0, ev1;
    logic [31:0] ed0, ed1;
    int          p, a;

    rst_n = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    idle();
    repeat (2) tick();
    for (int i = 0; i < 16; i++) begin
      load(i, 32'hA000_0000 | i);
      shadow[i] = 32'hA000_0000 | i;
    end
    load(5, 32'h3F80_0000);
    shadow[5] = 32'h3F80_0000;

    // Reset holds every output low even with both requesters valid
    req0_valid = 1'b1; req1_valid = 1'b1; req0_addr = 10'd9; req0_wdata = 32'h1234_5678;
    #1;
    chk("rst_ready0", rdy0[0], 0);
    chk("rst_ready1", rdy1[0], 0);
    chk("rst_mem_ce", mce[0], 0);
    chk("rst_mem_we", mwe[0], 0);
    chk("rst_mem_addr", maddr[0], 0);
    chk("rst_mem_wdata", mwd[0], 0);
    chk("rst_rsp0_valid", rv0[0], 0);
    chk("rst_rsp1_valid", rv1[0], 0);
    chk("rst_rsp0_data", rd0[0], 0);
    idle();
    tick();
    rst_n = 1'b1;

    // Single read, latency 1
    tick();
    req0_valid = 1'b1; req0_addr = 10'd5; #1;
    chk("sr_ready0", rdy0[0], 1);
    chk("sr_ready1", rdy1[0], 0);
    chk("sr_mem_ce", mce[0], 1);
    chk("sr_mem_we", mwe[0], 0);
    chk("sr_mem_addr", maddr[0], 5);
    tick();
    idle(); #1;
    chk("sr_rsp0_valid", rv0[0], 1);
    chk("sr_rsp0_data", rd0[0], 32'h3F80_0000);
    chk("sr_rsp1_valid", rv1[0], 0);
    tick(); #1;
    chk("sr_rsp0_done", rv0[0], 0);
    chk("sr_mem_ce_idle", mce[0], 0);

    // Contention from reset: grants alternate 0,1,0,1
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      tick();
      if (i < 8) begin
        req0_valid = 1'b1; req0_addr = 10'((i + 1) / 2);
        req1_valid = 1'b1; req1_addr = 10'(10 + i / 2);
      end else begin
        idle();
      end
      #1;
      if (i < 8) begin
        chk("ct_ready0", rdy0[0], (i % 2 == 0));
        chk("ct_ready1", rdy1[0], (i % 2 == 1));
      end
      if (i >= 1) begin
        p = i - 1;
        a = (p % 2 == 0) ? p / 2 : 10 + p / 2;
        chk("ct_rsp0_valid", rv0[0], (p % 2 == 0));
        chk("ct_rsp1_valid", rv1[0], (p % 2 == 1));
        if (p % 2 == 0) chk("ct_rsp0_data", rd0[0], 32'hA000_0000 | a);
        else            chk("ct_rsp1_data", rd1[0], 32'hA000_0000 | a);
      end
    end

    // Write by req1, then read of the same word by req0
    tick();
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 10'd7; req1_wdata = 32'h4000_0000; #1;
    chk("wr_ready1", rdy1[0], 1);
    chk("wr_mem_we", mwe[0], 1);
    chk("wr_mem_wdata", mwd[0], 32'h4000_0000);
    tick();
    idle(); req0_valid = 1'b1; req0_addr = 10'd7; #1;
    chk("wr_rsp1_none_a", rv1[0], 0);
    chk("wr_ready0", rdy0[0], 1);
    tick();
    idle(); #1;
    chk("wr_rsp0_valid", rv0[0], 1);
    chk("wr_rsp0_data", rd0[0], 32'h4000_0000);
    chk("wr_rsp1_none_b", rv1[0], 0);
    shadow[7] = 32'h4000_0000;

    // 16 back-to-back reads from req0
    for (int i = 0; i <= 16; i++) begin
      tick();
      if (i < 16) begin
        req0_valid = 1'b1; req0_addr = 10'(i);
      end else begin
        idle();
      end
      #1;
      if (i < 16) chk("tp_ready0", rdy0[0], 1);
      if (i >= 1) begin
        chk("tp_rsp0_valid", rv0[0], 1);
        chk("tp_rsp0_data", rd0[0], shadow[i-1]);
      end
    end
    tick(); #1;
    chk("tp_rsp0_end", rv0[0], 0);

    // Reset while a latency-2 read is in flight
    tick();
    req0_valid = 1'b1; req0_addr = 10'd3; #1;
    chk("rm_ready0", rdy0[1], 1);
    tick();
    idle(); rst_n = 1'b0; #1;
    chk("rm_rsp0_a", rv0[1], 0);
    chk("rm_rsp1_a", rv1[1], 0);
    req0_valid = 1'b1; req1_valid = 1'b1; req1_addr = 10'd10; #1;
    chk("rm_ready0_rst", rdy0[1], 0);
    chk("rm_ready1_rst", rdy1[1], 0);
    chk("rm_mem_ce_rst", mce[1], 0);
    tick(); #1;
    chk("rm_rsp0_b", rv0[1], 0);
    chk("rm_rsp1_b", rv1[1], 0);
    tick();
    rst_n = 1'b1; req0_addr = 10'd0; #1;
    chk("rm_first_ready0", rdy0[1], 1);
    chk("rm_first_ready1", rdy1[1], 0);
    tick();
    req0_valid = 1'b0; #1;
    chk("rm_second_ready1", rdy1[1], 1);
    chk("rm_rsp0_c", rv0[1], 0);
    tick();
    idle(); #1;
    chk("rm_rsp0_valid", rv0[1], 1);
    chk("rm_rsp0_data", rd0[1], 32'hA000_0000);
    tick(); #1;
    chk("rm_rsp1_valid", rv1[1], 1);
    chk("rm_rsp1_data", rd1[1], 32'hA000_000A);

    // Random mixed traffic against the latency-3 instance
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    pend0 = 1'b0; pend1 = 1'b0;
    for (int t = 0; t < 80; t++) begin
      tick();
      if (t < 72 && !pend0 && $urandom_range(0, 3) != 0) begin
        pend0 = 1'b1; req0_we = 1'($urandom_range(0, 1));
        req0_addr = 10'($urandom_range(0, 15)); req0_wdata = $urandom;
      end
      if (t < 72 && !pend1 && $urandom_range(0, 3) != 0) begin
        pend1 = 1'b1; req1_we = 1'($urandom_range(0, 1));
        req1_addr = 10'($urandom_range(0, 15)); req1_wdata = $urandom;
      end
      req0_valid = pend0; req1_valid = pend1;
      #1;
      ev0 = 1'b0; ev1 = 1'b0; ed0 = '0; ed1 = '0;
      for (int j = q.size() - 1; j >= 0; j--) begin
        if (q[j].due == t) begin
          if (q[j].id) begin ev1 = 1'b1; ed1 = q[j].data; end
          else         begin ev0 = 1'b1; ed0 = q[j].data; end
          q.delete(j);
        end
      end
      chk("rnd_rsp0_valid", rv0[2], ev0);
      chk("rnd_rsp1_valid", rv1[2], ev1);
      if (ev0) chk("rnd_rsp0_data", rd0[2], ed0);
      if (ev1) chk("rnd_rsp1_data", rd1[2], ed1);
      chk("rnd_one_grant", rdy0[2] & rdy1[2], 0);
      if (rdy0[2]) begin
        if (req0_we) shadow[req0_addr[3:0]] = req0_wdata;
        else q.push_back('{due: t + 3, id: 1'b0, data: shadow[req0_addr[3:0]]});
        pend0 = 1'b0;
      end
      if (rdy1[2]) begin
        if (req1_we) shadow[req1_addr[3:0]] = req1_wdata;
        else q.push_back('{due: t + 3, id: 1'b1, data: shadow[req1_addr[3:0]]});
        pend1 = 1'b0;
      end
    end
    chk("rnd_all_returned", q.size(), 0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
